insn_fetch: RTL

Instruction fetch stage for the single-clock processor. Walks a word-addressed program counter, issues read requests to the instruction memory, buffers returned words in a small in-order prefetch queue, and hands instructions to the decode stage over a valid/ready handshake. A redirect input reloads the PC, flushes the queue and discards any responses still in flight.

---
 rtl/insn_fetch_if.sv | 26 ++
 rtl/insn_fetch.sv | 112 +++++++++++
 2 files changed

// File: rtl/insn_fetch_if.sv
// Fetch-stage bus bundle: the instruction-memory request/response port and the
// decode-side instruction handshake. insn_fetch uses the master modport.
interface insn_fetch_if;
  // Handshake rule for both channels: a transfer happens on a rising edge where
  // valid (imem_req / insn_valid) and ready (imem_ready / insn_ready) are both high;
  // the data fields are meaningful only while valid is high.
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        insn_valid;
  logic [31:0] insn;
  logic [31:0] insn_pc;
  logic        insn_ready;

  modport master (
    output imem_req, imem_addr, insn_valid, insn, insn_pc,
    input  imem_ready, imem_rvalid, imem_rdata, insn_ready
  );

  modport slave (
    input  imem_req, imem_addr, insn_valid, insn, insn_pc,
    output imem_ready, imem_rvalid, imem_rdata, insn_ready
  );
endinterface

// File: rtl/insn_fetch.sv
// Instruction fetch: PC walk, in-order prefetch queue and redirect flush.
// Define INSN_FETCH_BYPASS_EN to forward a response to decode the same cycle when the queue is empty.
module insn_fetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         redirect,
  input  logic [31:0]  redirect_pc,
  insn_fetch_if.master bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;

  logic [31:0] word_q [DEPTH];
  logic [31:0] addr_q [DEPTH];
  logic [31:0] tag_q  [DEPTH];

  logic [CW:0] occupancy;
  logic        req, accept, fresh, byp, q_pop, q_push, q_nonempty;

  assign occupancy  = {1'b0, count_q} + {1'b0, outst_q};
  assign req        = !rst && !redirect && (occupancy < DEPTH_C);
  assign accept     = req && bus.imem_ready;
  // Responses landing while stale reads are pending, or during a redirect, are thrown away.
  assign fresh      = bus.imem_rvalid && (drop_q == '0) && !redirect;
  assign q_nonempty = (count_q != '0);

`ifdef INSN_FETCH_BYPASS_EN
  assign byp = fresh && !q_nonempty;
`else
  assign byp = 1'b0;
`endif

  assign q_pop  = q_nonempty && bus.insn_ready;
  assign q_push = fresh && !(byp && bus.insn_ready);

  assign bus.imem_req   = req;
  assign bus.imem_addr  = pc_q;
  assign bus.insn_valid = q_nonempty || byp;
  assign bus.insn       = q_nonempty ? word_q[head_q] : (byp ? bus.imem_rdata : 32'h0);
  assign bus.insn_pc    = q_nonempty ? addr_q[head_q] : (byp ? tag_q[tag_rd_q] : 32'h0);

  always_comb begin
    pc_d     = pc_q;
    count_d  = count_q;
    drop_d   = drop_q;
    head_d   = head_q;
    tail_d   = tail_q;
    tag_rd_d = tag_rd_q;
    tag_wr_d = tag_wr_q;
    outst_d  = outst_q + CW'(accept) - CW'(bus.imem_rvalid);
    if (accept) begin
      pc_d     = pc_q + 32'd1;
      tag_wr_d = tag_wr_q + AW'(1);
    end
    if (bus.imem_rvalid) tag_rd_d = tag_rd_q + AW'(1);
    if (redirect) begin
      // Everything still outstanding after this cycle belongs to the old stream.
      pc_d    = redirect_pc;
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
      drop_d  = outst_d;
    end else begin
      if (bus.imem_rvalid && (drop_q != '0)) drop_d = drop_q - CW'(1);
      if (q_push) tail_d = tail_q + AW'(1);
      if (q_pop)  head_d = head_q + AW'(1);
      count_d = count_q + CW'(q_push) - CW'(q_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      count_q  <= '0;
      outst_q  <= '0;
      drop_q   <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      tag_rd_q <= '0;
      tag_wr_q <= '0;
    end else begin
      pc_q     <= pc_d;
      count_q  <= count_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      tag_rd_q <= tag_rd_d;
      tag_wr_q <= tag_wr_d;
    end
  end

  // Storage needs no reset: the pointers and count decide what is live.
  always_ff @(posedge clk) begin
    if (q_push) begin
      word_q[tail_q] <= bus.imem_rdata;
      addr_q[tail_q] <= tag_q[tag_rd_q];
    end
    if (accept) tag_q[tag_wr_q] <= pc_q;
  end
endmodule
